// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, pixel type and pad-streamer state encoding for the 3x3 conv pixel path
package conv_pkg;
    localparam int PIXEL_DATAW = 8;
    localparam int IMG_WIDTH = 512;
    localparam int PAD_WIDTH = IMG_WIDTH + 2;
    typedef logic [PIXEL_DATAW-1:0] pixel_t;
    typedef enum logic [2:0] {IDLE, TOP, LPAD, BODY, RPAD, BOT} pad_state_t;
endpackage

// File: rtl/conv_out_reg.sv
// conv_out_reg: single-entry valid/ready output register carrying data and last
module conv_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         i_ready,
    output logic         free,
    output logic         o_valid,
    output logic [W-1:0] o_y,
    output logic         o_last
);
    assign free = !o_valid || i_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_y <= '0;
            o_last <= 1'b0;
        end else if (free) begin
            o_valid <= load_valid;
            o_y <= load_data;
            o_last <= load_last;
        end
    end
endmodule

// File: rtl/conv_pad_streamer.sv
// conv_pad_streamer: wraps a raw pixel stream in a one-pixel zero border for the 3x3 conv core
module conv_pad_streamer #(
    parameter int IMG_WIDTH = conv_pkg::IMG_WIDTH,
    parameter int PIXEL_DATAW = conv_pkg::PIXEL_DATAW,
    parameter int HEIGHT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [HEIGHT_W-1:0]    i_height,
    input  logic                   i_valid,
    input  logic [PIXEL_DATAW-1:0] i_x,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [PIXEL_DATAW-1:0] o_y,
    output logic                   o_last,
    output logic                   o_busy
);
    import conv_pkg::*;
    localparam int CW = $clog2(IMG_WIDTH + 2);
    localparam logic [CW-1:0] PAD_LAST = CW'(IMG_WIDTH + 1);
    localparam logic [CW-1:0] PIX_LAST = CW'(IMG_WIDTH - 1);
    pad_state_t state, nxt_state;
    logic [CW-1:0] col, nxt_col;
    logic [HEIGHT_W-1:0] row, nxt_row, h, nxt_h, row_inc;
    logic free, ld_valid, ld_last;
    logic [PIXEL_DATAW-1:0] ld_data;
    assign o_busy = state != IDLE;
    assign row_inc = row + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            h <= '0;
        end else begin
            state <= nxt_state;
            col <= nxt_col;
            row <= nxt_row;
            h <= nxt_h;
        end
    end
    // every state only moves when the output slot can take a beat
    always_comb begin
        nxt_state = state;
        nxt_col = col;
        nxt_row = row;
        nxt_h = h;
        ld_valid = 1'b0;
        ld_data = '0;
        ld_last = 1'b0;
        o_ready = 1'b0;
        case (state)
            IDLE: if (i_start) begin
                nxt_state = TOP;
                nxt_h = i_height;
                nxt_row = '0;
                nxt_col = '0;
            end
            TOP: if (free) begin
                ld_valid = 1'b1;
                nxt_col = col == PAD_LAST ? '0 : col + 1'b1;
                nxt_state = col != PAD_LAST ? TOP : h == '0 ? BOT : LPAD;
            end
            LPAD: if (free) begin
                ld_valid = 1'b1;
                nxt_state = BODY;
            end
            BODY: begin
                o_ready = free;
                if (free && i_valid) begin
                    ld_valid = 1'b1;
                    ld_data = i_x;
                    nxt_col = col == PIX_LAST ? '0 : col + 1'b1;
                    nxt_state = col == PIX_LAST ? RPAD : BODY;
                end
            end
            RPAD: if (free) begin
                ld_valid = 1'b1;
                nxt_row = row_inc;
                nxt_state = row_inc == h ? BOT : LPAD;
            end
            BOT: if (free) begin
                ld_valid = 1'b1;
                ld_last = col == PAD_LAST;
                nxt_col = ld_last ? '0 : col + 1'b1;
                nxt_state = ld_last ? IDLE : BOT;
            end
            default: nxt_state = IDLE;
        endcase
    end
    conv_out_reg #(.W(PIXEL_DATAW)) u_out (
        .clk(clk),
        .reset(reset),
        .load_valid(ld_valid),
        .load_data(ld_data),
        .load_last(ld_last),
        .i_ready(i_ready),
        .free(free),
        .o_valid(o_valid),
        .o_y(o_y),
        .o_last(o_last)
    );
endmodule

// File: tb/tb_conv_pad_streamer.sv
// tb_conv_pad_streamer: directed frames through the pad streamer with a small padded-raster model
module tb_conv_pad_streamer;
    localparam int W = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic i_start = 1'b0;
    logic [15:0] i_height = '0;
    logic i_valid = 1'b0;
    logic [7:0] i_x = '0;
    logic i_ready = 1'b1;
    logic o_ready, o_valid, o_last, o_busy;
    logic [7:0] o_y;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] got_y[$];
    logic got_last[$];
    int acc_g, gaps_g;
    bit saw_ready;

    always #5 clk = ~clk;

    conv_pad_streamer #(.IMG_WIDTH(W), .PIXEL_DATAW(8), .HEIGHT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .i_start(i_start),
        .i_height(i_height),
        .i_valid(i_valid),
        .i_x(i_x),
        .o_ready(o_ready),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_y(o_y),
        .o_last(o_last),
        .o_busy(o_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // zero border around a W x h image holding pixels 1, 2, 3, ... in raster order
    function automatic logic [7:0] exp_y(input int h, input int i);
        int r = i / (W + 2);
        int c = i % (W + 2);
        return (r == 0 || r == h + 1 || c == 0 || c == W + 1) ? 8'd0 : 8'((r - 1) * W + c);
    endfunction

    task automatic run_frame(input int h, input bit toggle, input int bub_at, input int bub_len, input int mid_start);
        int acc = 0;
        int bub = 0;
        int cyc = 0;
        int gaps = 0;
        bit done = 0;
        bit bubbled = 0;
        bit held = 0;
        logic [7:0] py = '0;
        logic pl = 1'b0;
        got_y.delete();
        got_last.delete();
        saw_ready = 0;
        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_height = 16'(h);
        i_ready = 1'b1;
        i_valid = h > 0;
        i_x = 8'd1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (o_ready) saw_ready = 1;
            if (held) begin
                check("hold_y", o_y, py);
                check("hold_last", o_last, pl);
            end
            held = o_valid && !i_ready;
            py = o_y;
            pl = o_last;
            if (got_y.size() > 0 && !o_valid) gaps++;
            if (o_valid && i_ready) begin
                got_y.push_back(o_y);
                got_last.push_back(o_last);
                if (o_last) done = 1;
            end
            if (i_valid && o_ready) acc++;
            @(posedge clk);
            #1;
            i_start = cyc == mid_start;
            i_height = 16'(h + 2);
            if (bub_len > 0 && acc == bub_at && !bubbled) begin
                bub = bub_len;
                bubbled = 1;
            end
            i_valid = bub == 0 && acc < W * h;
            if (bub > 0) bub--;
            i_x = 8'(acc + 1);
            i_ready = toggle ? !i_ready : 1'b1;
        end
        i_start = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        if (!done) check("frame_timeout", 0, 1);
        acc_g = acc;
        gaps_g = gaps;
    endtask

    task automatic check_frame(input string tag, input int h);
        int n = (W + 2) * (h + 2);
        check({tag, "_beats"}, got_y.size(), n);
        check({tag, "_inputs"}, acc_g, W * h);
        for (int i = 0; i < n && i < got_y.size(); i++) begin
            check($sformatf("%s_y%0d", tag, i), got_y[i], exp_y(h, i));
            check($sformatf("%s_last%0d", tag, i), got_last[i], i == n - 1);
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, o_busy, 0);
    endtask

    initial begin
        int cnt;
        #12;
        check("rst_valid", o_valid, 0);
        check("rst_y", o_y, 0);
        check("rst_last", o_last, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_ready, 0);
        @(negedge clk);
        reset = 1'b1;

        run_frame(2, 0, 0, 0, 0);
        check_frame("t1", 2);
        check("t1_no_gap", gaps_g, 0);

        run_frame(2, 1, 0, 0, 0);
        check_frame("t2", 2);

        run_frame(1, 0, 2, 3, 0);
        check_frame("t3", 1);
        check("t3_bubble", gaps_g > 0, 1);

        run_frame(0, 0, 0, 0, 0);
        check_frame("t4", 0);
        check("t4_no_ready", saw_ready, 0);

        run_frame(1, 0, 0, 0, 5);
        check_frame("t5a", 1);
        run_frame(1, 0, 0, 0, 0);
        check_frame("t5b", 1);

        @(posedge clk);
        #1;
        i_start = 1'b1;
        i_height = 16'd2;
        i_valid = 1'b1;
        i_x = 8'h55;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        cnt = 0;
        while (!o_ready && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("t6_reach_body", o_ready, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", o_valid, 0);
        check("t6_y", o_y, 0);
        check("t6_last", o_last, 0);
        check("t6_busy", o_busy, 0);
        check("t6_ready", o_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t6_idle_busy", o_busy, 0);
            check("t6_idle_valid", o_valid, 0);
        end
        i_valid = 1'b0;
        run_frame(1, 0, 0, 0, 0);
        check_frame("t6_after", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
